// File: rtl/span_out_gen.sv
// span_out_gen: queued span rasteriser output stage. Accepts spans through valid/ready and
// emits one (x, y) pixel per cycle in ascending x, streaming queued spans back to back.
module span_out_gen #(
   parameter int unsigned CW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    span_valid,
   output logic                    span_ready,
   input  logic [CW-1:0]           span_xl,
   input  logic [CW-1:0]           span_xr,
   input  logic [CW-1:0]           span_y,
   output logic [CW-1:0]           xout,
   output logic [CW-1:0]           yout,
   output logic                    po,
   input  logic                    pix_ready,
   output logic                    busy,
   output logic                    span_done,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam logic [AddrW:0] FullLevel = (AddrW + 1)'(DEPTH);

   typedef enum logic {StIdle, StRun} state_e;

   logic [3*CW-1:0] mem [DEPTH];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   state_e           state_q;
   logic [CW-1:0]    xend_q;
   logic             empty, push, pop, last_pix;
   logic [CW-1:0]    hd_xl, hd_xr, hd_y, hd_lo, hd_hi;

   assign span_ready = (level != FullLevel);
   assign empty      = (level == '0);
   assign push       = span_valid && span_ready;
   assign last_pix   = (state_q == StRun) && pix_ready && (xout == xend_q);
   // The FSM pops when idle, or on the edge that accepts the last pixel of the current span.
   assign pop        = !empty && ((state_q == StIdle) || last_pix);
   assign busy       = (state_q == StRun) || !empty;

   assign {hd_xl, hd_xr, hd_y} = mem[rd_ptr_q];
   assign hd_lo = (hd_xl < hd_xr) ? hd_xl : hd_xr;
   assign hd_hi = (hd_xl < hd_xr) ? hd_xr : hd_xl;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {span_xl, span_xr, span_y};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         xout      <= '0;
         yout      <= '0;
         xend_q    <= '0;
         po        <= 1'b0;
         span_done <= 1'b0;
      end else begin
         span_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  xout    <= hd_lo;
                  xend_q  <= hd_hi;
                  yout    <= hd_y;
                  po      <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (pix_ready) begin
                  // End test precedes the increment, so xend = 2^CW-1 never wraps.
                  if (xout != xend_q) begin
                     xout <= xout + 1'b1;
                  end else begin
                     span_done <= 1'b1;
                     if (pop) begin
                        xout   <= hd_lo;
                        xend_q <= hd_hi;
                        yout   <= hd_y;
                     end else begin
                        po      <= 1'b0;
                        state_q <= StIdle;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_span_out_gen.sv
// Randomised and directed bench for span_out_gen against a queue-based reference model.
module tb_span_out_gen;

   localparam int unsigned CW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [CW-1:0] lo;
      logic [CW-1:0] hi;
      logic [CW-1:0] y;
   } span_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          span_valid = 1'b0;
   logic          span_ready;
   logic [CW-1:0] span_xl = '0;
   logic [CW-1:0] span_xr = '0;
   logic [CW-1:0] span_y = '0;
   logic [CW-1:0] xout, yout;
   logic          po;
   logic          pix_ready = 1'b1;
   logic          busy;
   logic          span_done;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   span_out_gen #(.CW(CW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .span_valid(span_valid), .span_ready(span_ready),
      .span_xl(span_xl), .span_xr(span_xr), .span_y(span_y), .xout(xout), .yout(yout),
      .po(po), .pix_ready(pix_ready), .busy(busy), .span_done(span_done), .level(level)
   );

   // Reference model: pending spans as a queue, plus the span currently being drawn.
   span_t         pend[$];
   span_t         m_ns;
   span_t         m_cur;
   bit            m_po = 1'b0;
   bit            m_done = 1'b0;
   bit            m_push;
   logic [CW-1:0] m_x = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pend.delete();
         m_po   = 1'b0;
         m_done = 1'b0;
         m_x    = '0;
         m_cur  = '0;
      end else begin
         m_push  = span_valid && (pend.size() < DEPTH);
         m_ns.lo = (span_xl < span_xr) ? span_xl : span_xr;
         m_ns.hi = (span_xl < span_xr) ? span_xr : span_xl;
         m_ns.y  = span_y;
         m_done  = 1'b0;
         if (m_po) begin
            if (pix_ready) begin
               if (m_x == m_cur.hi) begin
                  m_done = 1'b1;
                  if (pend.size() != 0) begin
                     m_cur = pend.pop_front();
                     m_x   = m_cur.lo;
                  end else begin
                     m_po = 1'b0;
                  end
               end else begin
                  m_x = m_x + 1'b1;
               end
            end
         end else if (pend.size() != 0) begin
            m_cur = pend.pop_front();
            m_x   = m_cur.lo;
            m_po  = 1'b1;
         end
         if (m_push) pend.push_back(m_ns);
      end
   end

   int n_total = 0;
   int n_bad = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   int last_x = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Check outputs mid-cycle against the model, then advance to just past the next edge.
   task automatic tick();
      @(negedge clk);
      if (po && pix_ready) begin
         acc_cnt++;
         last_x = int'(xout);
      end
      if (span_done) done_cnt++;
      check_eq("po", po, m_po);
      check_eq("span_done", span_done, m_done);
      check_eq("level", level, pend.size());
      check_eq("span_ready", span_ready, pend.size() < DEPTH);
      check_eq("busy", busy, m_po || (pend.size() != 0));
      if (m_po) begin
         check_eq("xout", xout, m_x);
         check_eq("yout", yout, m_cur.y);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int xl, input int xr, input int y);
      bit ok;
      ok         = 1'b0;
      span_valid = 1'b1;
      span_xl    = CW'(xl);
      span_xr    = CW'(xr);
      span_y     = CW'(y);
      for (int k = 0; k < 200 && !ok; k++) begin
         ok = span_ready;
         tick();
      end
      span_valid = 1'b0;
      check_eq("push_accepted", ok, 1'b1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 2000 && busy; k++) tick();
      tick();
      check_eq("idle_timeout_busy", busy, 1'b0);
   endtask

   initial begin
      int a0, d0, b, l, e;
      bit ok;

      tick();
      tick();
      check_eq("rst_xout", xout, 0);
      check_eq("rst_yout", yout, 0);
      check_eq("rst_po", po, 0);
      check_eq("rst_done", span_done, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ready", span_ready, 1);
      reset = 1'b0;
      tick();

      // Basic span
      a0 = acc_cnt; d0 = done_cnt;
      push(3, 7, 10);
      wait_idle();
      check_eq("basic_pixels", acc_cnt - a0, 5);
      check_eq("basic_done", done_cnt - d0, 1);
      check_eq("basic_last_x", last_x, 7);

      // Swapped endpoints followed by a single-pixel span
      a0 = acc_cnt; d0 = done_cnt;
      push(9, 5, 2);
      push(4, 4, 3);
      wait_idle();
      check_eq("swap_pixels", acc_cnt - a0, 6);
      check_eq("swap_done", done_cnt - d0, 2);
      check_eq("swap_last_x", last_x, 4);

      // Backpressure while xout = 1
      a0 = acc_cnt;
      push(0, 3, 1);
      for (int k = 0; k < 50 && !(po && xout == 1); k++) tick();
      check_eq("bp_reach_x1", xout, 1);
      pix_ready = 1'b0;
      repeat (3) tick();
      check_eq("bp_hold_po", po, 1);
      check_eq("bp_hold_x", xout, 1);
      pix_ready = 1'b1;
      wait_idle();
      check_eq("bp_pixels", acc_cnt - a0, 4);

      // Fill the queue with the consumer stalled, then offer one more span
      d0 = done_cnt;
      pix_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) push(i * 10 + 5, i * 10, 20 + i);
      check_eq("full_level", level, DEPTH);
      check_eq("full_ready", span_ready, 0);
      span_valid = 1'b1;
      span_xl = 8'd100; span_xr = 8'd102; span_y = 8'd30;
      repeat (3) begin
         check_eq("full_stall", span_ready, 0);
         tick();
      end
      pix_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         ok = span_ready;
         tick();
      end
      span_valid = 1'b0;
      check_eq("full_extra_accepted", ok, 1);
      wait_idle();
      check_eq("full_done", done_cnt - d0, DEPTH + 2);
      check_eq("full_last_x", last_x, 102);

      // Top-of-range span must stop at 255
      a0 = acc_cnt; d0 = done_cnt;
      push(250, 255, 0);
      wait_idle();
      check_eq("bnd_pixels", acc_cnt - a0, 6);
      check_eq("bnd_last_x", last_x, 255);
      check_eq("bnd_done", done_cnt - d0, 1);

      // Reset in the middle of a span with two more queued
      push(0, 20, 7);
      push(30, 31, 8);
      push(40, 41, 9);
      for (int k = 0; k < 100 && !(po && xout == 5); k++) tick();
      check_eq("rm_reach_x5", xout, 5);
      check_eq("rm_level_before", level, 2);
      reset = 1'b1;
      #1;
      check_eq("rm_po", po, 0);
      check_eq("rm_level", level, 0);
      check_eq("rm_xout", xout, 0);
      check_eq("rm_busy", busy, 0);
      tick();
      tick();
      reset = 1'b0;
      a0 = acc_cnt; d0 = done_cnt;
      repeat (30) tick();
      check_eq("rm_no_pixels", acc_cnt - a0, 0);
      check_eq("rm_no_done", done_cnt - d0, 0);

      // Random traffic with random backpressure; producer holds a stalled span
      ok = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (!span_valid || ok) begin
            if ($urandom_range(0, 2) == 0) begin
               b = int'($urandom_range(0, 255));
               l = int'($urandom_range(0, 6));
               e = (b + l > 255) ? 255 : b + l;
               span_valid = 1'b1;
               if ($urandom_range(0, 1) == 1) begin
                  span_xl = CW'(e); span_xr = CW'(b);
               end else begin
                  span_xl = CW'(b); span_xr = CW'(e);
               end
               span_y = CW'($urandom_range(0, 255));
            end else begin
               span_valid = 1'b0;
            end
         end
         pix_ready = ($urandom_range(0, 3) != 0);
         ok = span_ready;
         tick();
      end
      span_valid = 1'b0;
      pix_ready = 1'b1;
      wait_idle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/span_out_gen.md
# span_out_gen

Parametrised output stage for the trapezoid rendering engine. It accepts horizontal spans (left x, right x, scanline y) through a valid/ready handshake into an internal queue. It emits them one pixel per cycle as (xout, yout) under a downstream valid/ready handshake. Compared with the single-span output stage, it adds:
- configurable coordinate width;
- span buffering;
- backpressure in both directions;
- automatic endpoint ordering;
- back-to-back spans with no idle cycles;
- a per-span completion pulse.

## Interface
- CW, 8: coordinate width in bits for x and y.
- DEPTH, 4: span queue depth, in entries; must be a power of 2 and at least 2.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- span_valid  in  1  a span is offered on span_xl/span_xr/span_y.
- span_ready  out  1  the queue can accept a span; equals !full.
- span_xl  in  CW  first span endpoint.
- span_xr  in  CW  second span endpoint.
- span_y  in  CW  scanline of the span.
- xout  out  CW  current pixel x.
- yout  out  CW  current pixel y.
- po  out  1  pixel valid.
- pix_ready  in  1  downstream accepts the pixel.
- busy  out  1  a span is in progress or the queue is non-empty.
- span_done  out  1  one-cycle pulse marking completion of a span.
- level  out  $clog2(DEPTH)+1  queue occupancy, from 0 to DEPTH.

## Operation
- Push: span_valid && span_ready at a clock edge writes {span_xl, span_xr, span_y} into the FIFO tail.
  - span_ready depends only on full. It is never raised combinationally by a same-cycle pop.
- Pop happens at the edge where the FSM loads a span. The loaded values are:
  - x = min(span_xl, span_xr);
  - xend = max(span_xl, span_xr);
  - yout = span_y.
- Ordering: spans with span_xl > span_xr are swapped. Pixels are always emitted in ascending x.
- FSM has two states, IDLE and RUN.
  - IDLE: po=0. If the queue is non-empty: pop, load, go to RUN, po=1.
  - RUN: po=1. A pixel is accepted when po && pix_ready.
    - If the pixel is accepted and xout != xend: xout <= xout+1.
    - If the pixel is accepted and xout == xend, the span is complete:
      - queue non-empty: pop and load the next span in the same edge and stay in RUN (no bubble);
      - queue empty: go to IDLE, po=0.
    - On a span-complete edge, span_done <= 1 for exactly one cycle.
    - If pix_ready=0: xout, yout and po hold. There is no skipping or duplication.
- Arithmetic: the end test is an equality compare against xend, made before the increment.
  - xout never wraps. xend = 2^CW-1 terminates correctly.
  - xl == xr emits exactly one pixel.
- A simultaneous push and pop in one edge leaves level unchanged. FIFO pointers wrap modulo DEPTH.
- busy = (state==RUN) || (level != 0).

## Timing
- Reset values:
  - xout=0, yout=0, po=0, span_done=0, level=0, busy=0;
  - span_ready=1, the queue is empty, state=IDLE.
- Reset mid-span: everything above is applied asynchronously, queued spans are discarded, and no span_done is produced.
- Latency: a span pushed at edge E0 into an empty queue while IDLE is popped at E0+1. Its first pixel is valid in the cycle after E0+1.
- Throughput: one pixel per cycle while pix_ready=1. Consecutive queued spans stream with zero idle cycles.
- span_done is high in the cycle after the edge that accepts a span's last pixel. It is concurrent with the next span's first pixel when streaming.
- Full: with level == DEPTH, span_ready=0. An offered span is held by the producer and not lost.
- Outputs xout, yout, po, span_done and level are registered. span_ready and busy are combinational from registered state.

## Test plan
- Basic span: push (xl=3, xr=7, y=10) with pix_ready=1.
  - Required: po high for 5 cycles with xout 3,4,5,6,7 and yout=10; then po=0; one span_done pulse; busy falls.
- Swap and single pixel: push (xl=9, xr=5, y=2), then (xl=4, xr=4, y=3).
  - Required: xout 5..9 at y=2, then xout=4 at y=3 with no bubble; two span_done pulses.
- Backpressure: span (0,3,1); drop pix_ready for 3 cycles while xout=1.
  - Required: xout=1 and po=1 held; the sequence resumes 2,3; exactly 4 accepted pixels.
- Full queue: hold pix_ready=0 and push DEPTH+1 spans.
  - Required: level=DEPTH and span_ready=0, the extra span is stalled; after release all spans are emitted in order.
- Boundary with CW=8: span (250,255,0).
  - Required: xout 250..255, terminating at 255 with no wrap to 0.
- Reset mid-span: assert reset at xout=5 of span (0,20,7) with 2 spans queued.
  - Required: po=0, level=0, xout=0 immediately; no further pixels and no span_done after release.
